// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers pixel position, lock status and per-frame statistics
// from a received hsync/vsync/rgb stream sampled on pixel_tick strobes.
// Latency: one tick from input sample (S1) to registered position/pixel
// outputs; outputs hold between ticks. No backpressure: input accepted every tick.
// Optional feature: define VGA_SYNC_RX_CRC_EN to add a per-frame CRC-8 of the
// active pixels (frame_crc); otherwise frame_crc is tied to zero.
module vga_sync_rx #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_ACTIVE    = 480,
  parameter bit SYNC_POL    = 1'b1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixel_tick,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [7:0]  rgb_in,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        video_on,
  output logic [7:0]  rgb_out,
  output logic        locked,
  output logic        frame_start,
  output logic        timing_err,
  output logic        probe_valid,
  output logic [7:0]  probe_rgb,
  output logic [10:0] line_len,
  output logic [10:0] frame_lines,
  output logic [7:0]  frame_crc
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  localparam logic [10:0] CNT_MAX   = 11'h7FF;
  localparam logic [10:0] CNT_SAT_M = 11'h7FE;
  localparam logic [10:0] H_TOT11   = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT11   = 11'(V_TOTAL);
  localparam logic [10:0] H_LO      = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_HI      = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [10:0] V_LO      = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_HI      = 11'(V_SYNC + V_BP + V_ACTIVE - 1);

  // Stage S1 and the previous S1 sync levels used for edge detection
  logic       hs1_q, vs1_q, hs_prev_q, vs_prev_q;
  logic [7:0] rgb1_q;

  // Position counters and per-edge statistics
  logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [10:0] line_len_q, frame_lines_q;

  // Lock state machine
  state_t     state_q;
  logic [7:0] good_cnt_q;
  logic       frame_ok_q;
  logic       locked_q, timing_err_q;

  // Registered video-side outputs
  logic [9:0] pixel_x_q, pixel_y_q;
  logic       video_on_q, frame_start_q, probe_valid_q;
  logic [7:0] rgb_out_q, probe_rgb_q;

  // Per-tick events
  logic       hedge, vedge;
  logic       line_bad, frame_bad, frame_good;
  logic       sat_evt, lock_gain, lock_nxt;
  logic       video_nxt, probe_hit;
  logic [9:0] pixel_x_nxt, pixel_y_nxt;

  // Edges only exist on ticks; the sync is "new" when S1 is asserted and the
  // sample before it was not.
  assign hedge = pixel_tick && (hs1_q == SYNC_POL) && (hs_prev_q != SYNC_POL);
  assign vedge = pixel_tick && (vs1_q == SYNC_POL) && (vs_prev_q != SYNC_POL);

  // A line is judged at its terminating hsync edge, a frame at its vsync edge.
  assign line_bad   = hedge && ((hcnt_q + 11'd1) != H_TOT11);
  assign frame_bad  = vedge && ((vcnt_q + 11'd1) != V_TOT11);
  assign frame_good = frame_ok_q && !line_bad && !frame_bad;

  // Next-state counters: hcnt restarts at hsync, vcnt advances per line and
  // restarts at vsync (after the line check above has used the old hcnt).
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pixel_tick) begin
      if (hedge) begin
        hcnt_d = '0;
      end else if (hcnt_q != CNT_MAX) begin
        hcnt_d = hcnt_q + 11'd1;
      end
      if (vedge) begin
        vcnt_d = '0;
      end else if (hedge && (vcnt_q != CNT_MAX)) begin
        vcnt_d = vcnt_q + 11'd1;
      end
    end
  end

  // Saturation fires once, on the tick a counter first reaches its ceiling.
  assign sat_evt = (hcnt_d == CNT_MAX && hcnt_q == CNT_SAT_M) ||
                   (vcnt_d == CNT_MAX && vcnt_q == CNT_SAT_M);

  assign lock_gain = (state_q == ST_ACQUIRE) && vedge && frame_good &&
                     ((int'(good_cnt_q) + 1) >= LOCK_FRAMES);

  // Lock status that the FSM will hold after this edge; used so that the
  // video outputs drop on the very edge that detects a timing fault.
  assign lock_nxt = !sat_evt &&
                    (((state_q == ST_LOCKED) && !line_bad && !frame_bad) || lock_gain);

  assign video_nxt = lock_nxt &&
                     (hcnt_d >= H_LO) && (hcnt_d <= H_HI) &&
                     (vcnt_d >= V_LO) && (vcnt_d <= V_HI);

  assign pixel_x_nxt = video_nxt ? 10'(hcnt_d - H_LO) : 10'd0;
  assign pixel_y_nxt = video_nxt ? 10'(vcnt_d - V_LO) : 10'd0;

  assign probe_hit = pixel_tick && video_nxt &&
                     (pixel_x_nxt == probe_x) && (pixel_y_nxt == probe_y);

  // Input capture into S1 and the one-sample sync history
  always_ff @(posedge clk) begin
    if (!reset) begin
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
      rgb1_q    <= 8'd0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
    end else if (pixel_tick) begin
      hs1_q     <= hsync_in;
      vs1_q     <= vsync_in;
      rgb1_q    <= rgb_in;
      hs_prev_q <= hs1_q;
      vs_prev_q <= vs1_q;
    end
  end

  // Position counters and the measured line length / frame height
  always_ff @(posedge clk) begin
    if (!reset) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      if (hedge) begin
        line_len_q <= hcnt_q + 11'd1;
      end
      if (vedge) begin
        frame_lines_q <= vcnt_q + 11'd1;
      end
    end
  end

  // Lock FSM: acquire on consecutive good frames, drop on any bad edge or
  // counter saturation (saturation means the sync has disappeared)
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_UNLOCKED;
      good_cnt_q   <= '0;
      frame_ok_q   <= 1'b0;
      locked_q     <= 1'b0;
      timing_err_q <= 1'b0;
    end else begin
      timing_err_q <= 1'b0;
      locked_q     <= lock_nxt;
      if (sat_evt) begin
        state_q      <= ST_UNLOCKED;
        timing_err_q <= 1'b1;
      end else begin
        case (state_q)
          ST_UNLOCKED: begin
            if (vedge) begin
              state_q    <= ST_ACQUIRE;
              good_cnt_q <= '0;
              frame_ok_q <= 1'b1;
            end
          end
          ST_ACQUIRE: begin
            if (line_bad) begin
              frame_ok_q <= 1'b0;
            end
            if (vedge) begin
              // The frame that just ended is scored; the next one starts clean.
              frame_ok_q <= 1'b1;
              if (lock_gain) begin
                state_q    <= ST_LOCKED;
                good_cnt_q <= '0;
              end else if (frame_good) begin
                good_cnt_q <= good_cnt_q + 8'd1;
              end else begin
                good_cnt_q <= '0;
              end
            end
          end
          ST_LOCKED: begin
            if (line_bad || frame_bad) begin
              state_q      <= ST_UNLOCKED;
              timing_err_q <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_UNLOCKED;
          end
        endcase
      end
    end
  end

  // Aligned pixel outputs, frame marker and probe capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      video_on_q    <= 1'b0;
      rgb_out_q     <= '0;
      frame_start_q <= 1'b0;
      probe_valid_q <= 1'b0;
      probe_rgb_q   <= '0;
    end else begin
      frame_start_q <= vedge;
      probe_valid_q <= probe_hit;
      if (pixel_tick) begin
        video_on_q <= video_nxt;
        pixel_x_q  <= pixel_x_nxt;
        pixel_y_q  <= pixel_y_nxt;
        rgb_out_q  <= video_nxt ? rgb1_q : 8'd0;
      end
      if (probe_hit) begin
        probe_rgb_q <= rgb1_q;
      end
    end
  end

`ifdef VGA_SYNC_RX_CRC_EN
  logic [7:0] crc_acc_q, frame_crc_q;

  // CRC-8, polynomial 0x07, MSB first, one byte per call
  function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] dat);
    logic [7:0] r;
    r = crc ^ dat;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  // Accumulate over visible pixels; publish and restart at each vsync edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      crc_acc_q   <= '0;
      frame_crc_q <= '0;
    end else if (pixel_tick) begin
      if (vedge) begin
        frame_crc_q <= crc_acc_q;
        crc_acc_q   <= video_nxt ? crc8_upd(8'h00, rgb1_q) : 8'h00;
      end else if (video_nxt) begin
        crc_acc_q <= crc8_upd(crc_acc_q, rgb1_q);
      end
    end
  end

  assign frame_crc = frame_crc_q;
`else
  assign frame_crc = 8'h00;
`endif

  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign video_on    = video_on_q;
  assign rgb_out     = rgb_out_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign timing_err  = timing_err_q;
  assign probe_valid = probe_valid_q;
  assign probe_rgb   = probe_rgb_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Scoreboard bench for vga_sync_rx on a reduced raster (40x16 ticks/lines).
// Random pixel_tick gaps; a frame-level reference model predicts each sample.
// A monitor pops one expectation per tick once the one-tick pipeline is full.
module tb_vga_sync_rx;

  localparam int H_TOTAL = 40, H_SYNC = 4, H_BP = 6, H_ACTIVE = 24;
  localparam int V_TOTAL = 16, V_SYNC = 2, V_BP = 3, V_ACTIVE = 9;
  localparam int LOCK_FRAMES = 2;
  localparam int H_A0 = H_SYNC + H_BP;
  localparam int V_A0 = V_SYNC + V_BP;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pixel_tick = 1'b0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0;
  logic [7:0]  rgb_in = 8'd0;
  logic [9:0]  probe_x = 10'(H_ACTIVE - 1), probe_y = 10'(V_ACTIVE - 1);
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on, locked, frame_start, timing_err, probe_valid;
  logic [7:0]  rgb_out, probe_rgb, frame_crc;
  logic [10:0] line_len, frame_lines;

  vga_sync_rx #(
    .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE),
    .SYNC_POL(1'b1), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .pixel_tick(pixel_tick),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
    .probe_x(probe_x), .probe_y(probe_y),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on), .rgb_out(rgb_out),
    .locked(locked), .frame_start(frame_start), .timing_err(timing_err),
    .probe_valid(probe_valid), .probe_rgb(probe_rgb),
    .line_len(line_len), .frame_lines(frame_lines), .frame_crc(frame_crc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        locked;
    logic        video;
    logic [9:0]  px;
    logic [9:0]  py;
    logic [7:0]  rgb;
    logic        fs;
    logic        te;
    logic        pv;
    logic [7:0]  prgb;
    logic [10:0] ll;
    logic [10:0] fl;
    logic [7:0]  crc;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   rgb_mode = 0;

  // Reference model state: sample index, index of the last hsync edge,
  // lines seen since the last vsync edge, and the frame-level lock status.
  int         mk, mkh, mnh, mmode, mgood;
  bit         mfok, mprev_hs, mprev_vs;
  logic [10:0] mll, mfl;
  logic [7:0]  mprgb, macc, mfcrc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_crc8(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] r;
    r = crc ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  task automatic model_reset();
    mk = 0; mkh = -2; mnh = 0; mmode = 0; mgood = 0; mfok = 0;
    mprev_hs = 0; mprev_vs = 0;
    mll = '0; mfl = '0; mprgb = '0; macc = '0; mfcrc = '0;
  endtask

  task automatic model_step(input bit hs, input bit vs, input logic [7:0] rgb);
    exp_t e;
    bit hedge, vedge, linebad, vbad, sat;
    int oldh, oldv, hpos, vpos;
    hedge = hs && !mprev_hs;
    vedge = vs && !mprev_vs;
    mprev_hs = hs; mprev_vs = vs;
    oldh = mk - 1 - mkh; if (oldh > 2047) oldh = 2047;
    oldv = mnh;
    linebad = 0; vbad = 0; sat = 0;
    if (hedge) begin
      mll = 11'(oldh + 1);
      linebad = (oldh + 1 != H_TOTAL);
      mkh = mk;
    end
    hpos = mk - mkh; if (hpos > 2047) hpos = 2047;
    if (!hedge && (mk - mkh) == 2047) sat = 1;
    if (hedge && mnh < 2047) begin
      if (!vedge && mnh == 2046) sat = 1;
      mnh++;
    end
    if (vedge) begin
      mfl = 11'(oldv + 1);
      vbad = (oldv + 1 != V_TOTAL);
      mnh = 0;
    end
    vpos = mnh;
    e = '0;
    if (sat) begin
      mmode = 0; e.te = 1;
    end else if (mmode == 0) begin
      if (vedge) begin mmode = 1; mgood = 0; mfok = 1; end
    end else if (mmode == 1) begin
      if (linebad) mfok = 0;
      if (vedge) begin
        if (mfok && !vbad) begin
          mgood++;
          if (mgood >= LOCK_FRAMES) begin mmode = 2; mgood = 0; end
        end else mgood = 0;
        mfok = 1;
      end
    end else begin
      if (linebad || vbad) begin mmode = 0; e.te = 1; end
    end
    e.locked = (mmode == 2);
    e.video  = e.locked && hpos >= H_A0 && hpos < H_A0 + H_ACTIVE &&
               vpos >= V_A0 && vpos < V_A0 + V_ACTIVE;
    e.px  = e.video ? 10'(hpos - H_A0) : 10'd0;
    e.py  = e.video ? 10'(vpos - V_A0) : 10'd0;
    e.rgb = e.video ? rgb : 8'd0;
    e.pv  = e.video && e.px == probe_x && e.py == probe_y;
    if (e.pv) mprgb = rgb;
    e.prgb = mprgb;
    e.fs = vedge;
    e.ll = mll;
    e.fl = mfl;
`ifdef VGA_SYNC_RX_CRC_EN
    if (vedge) begin mfcrc = macc; macc = 8'd0; end
    if (e.video) macc = ref_crc8(macc, rgb);
`endif
    e.crc = mfcrc;
    expq.push_back(e);
    mk++;
  endtask

  // Monitor: outputs for sample j are visible after the tick that carries j+1
  bit mon_tick;
  always @(posedge clk) begin
    exp_t e;
    mon_tick = pixel_tick && reset;
    #1;
    if (mon_tick) begin
      if (expq.size() >= 2) begin
        e = expq.pop_front();
        chk("locked",      int'(locked),      int'(e.locked));
        chk("video_on",    int'(video_on),    int'(e.video));
        chk("pixel_x",     int'(pixel_x),     int'(e.px));
        chk("pixel_y",     int'(pixel_y),     int'(e.py));
        chk("rgb_out",     int'(rgb_out),     int'(e.rgb));
        chk("frame_start", int'(frame_start), int'(e.fs));
        chk("timing_err",  int'(timing_err),  int'(e.te));
        chk("probe_valid", int'(probe_valid), int'(e.pv));
        chk("probe_rgb",   int'(probe_rgb),   int'(e.prgb));
        chk("line_len",    int'(line_len),    int'(e.ll));
        chk("frame_lines", int'(frame_lines), int'(e.fl));
        chk("frame_crc",   int'(frame_crc),   int'(e.crc));
      end
    end else if (reset) begin
      chk("idle_frame_start", int'(frame_start), 0);
      chk("idle_timing_err",  int'(timing_err),  0);
      chk("idle_probe_valid", int'(probe_valid), 0);
    end
  end

  task automatic drive_sample(input bit hs, input bit vs, input logic [7:0] rgb);
    bit done;
    done = 0;
    while (!done) begin
      @(negedge clk);
      if ($urandom_range(0, 3) != 0) begin
        pixel_tick = 1'b1;
        hsync_in = hs; vsync_in = vs; rgb_in = rgb;
        model_step(hs, vs, rgb);
        done = 1;
      end else begin
        pixel_tick = 1'b0;
      end
    end
  endtask

  // One-clock reset with pixel_tick high; every output must be zero after it
  task automatic do_reset(input logic [9:0] px, input logic [9:0] py);
    @(negedge clk);
    reset = 1'b0;
    pixel_tick = 1'b1;
    probe_x = px; probe_y = py;
    @(posedge clk);
    #1;
    chk("rst_pixel_x",     int'(pixel_x), 0);
    chk("rst_pixel_y",     int'(pixel_y), 0);
    chk("rst_video_on",    int'(video_on), 0);
    chk("rst_rgb_out",     int'(rgb_out), 0);
    chk("rst_locked",      int'(locked), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_timing_err",  int'(timing_err), 0);
    chk("rst_probe_valid", int'(probe_valid), 0);
    chk("rst_probe_rgb",   int'(probe_rgb), 0);
    chk("rst_line_len",    int'(line_len), 0);
    chk("rst_frame_lines", int'(frame_lines), 0);
    chk("rst_frame_crc",   int'(frame_crc), 0);
    @(negedge clk);
    reset = 1'b1;
    pixel_tick = 1'b0;
    expq.delete();
    model_reset();
  endtask

  function automatic logic [7:0] pick_rgb(input int l, input int c);
    bit act;
    act = c >= H_A0 && c < H_A0 + H_ACTIVE && l >= V_A0 && l < V_A0 + V_ACTIVE;
    if (rgb_mode == 2) return 8'hFF;
    if (rgb_mode == 0 && act) return 8'(c - H_A0);
    return 8'($urandom_range(0, 255));
  endfunction

  // One frame; optionally one line of altered length, optionally a reset
  // mid-line inside the active area of line rst_line.
  task automatic send_frame(input int bad_line, input int bad_len, input int rst_line);
    int len;
    for (int l = 0; l < V_TOTAL; l++) begin
      len = (l == bad_line) ? bad_len : H_TOTAL;
      for (int c = 0; c < len; c++) begin
        if (l == rst_line && c == H_A0 + 5) do_reset(10'(H_ACTIVE), 10'(V_ACTIVE - 1));
        drive_sample(c < H_SYNC, l < V_SYNC, pick_rgb(l, c));
      end
    end
  endtask

  initial begin
    model_reset();
    do_reset(10'(H_ACTIVE - 1), 10'(V_ACTIVE - 1));

    // Clean timing, rgb = pixel_x: lock at the third vsync edge
    rgb_mode = 0;
    repeat (4) send_frame(-1, 0, -1);
    @(negedge clk); pixel_tick = 1'b0;
    chk("A_locked", int'(locked), 1);
    chk("A_line_len", int'(line_len), H_TOTAL);
    chk("A_frame_lines", int'(frame_lines), V_TOTAL);
    chk("A_probe_rgb", int'(probe_rgb), H_ACTIVE - 1);

    // Short line while locked, then a bad frame during acquisition
    rgb_mode = 1;
    send_frame(7, H_TOTAL - 1, -1);
    chk("B_unlocked", int'(locked), 0);
    send_frame(-1, 0, -1);
    send_frame(3, H_TOTAL + 1, -1);
    repeat (3) send_frame(-1, 0, -1);
    chk("B_relocked", int'(locked), 1);

    // Sync vanishes long enough for the line counter to saturate
    for (int i = 0; i < 2100; i++) drive_sample(1'b0, 1'b0, 8'($urandom_range(0, 255)));
    chk("C_unlocked", int'(locked), 0);
    chk("C_video_off", int'(video_on), 0);
    rgb_mode = 2;
    repeat (5) send_frame(-1, 0, -1);
    chk("C_relocked", int'(locked), 1);

    // Reset mid-line while locked; probe moved out of range
    rgb_mode = 0;
    send_frame(-1, 0, 6);
    chk("D_after_reset", int'(locked), 0);
    repeat (3) send_frame(-1, 0, -1);
    chk("D_relocked", int'(locked), 1);
    send_frame(-1, 0, -1);

    @(negedge clk); pixel_tick = 1'b0;
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running at %0t, limit 800000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
